// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RX decapsulation path.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_TLP = 16'h88B5;
  localparam int          HDR_BYTES    = 16;
  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

  // FIFO word layout, identical to the TX path.
  localparam int DIN_LAST = 72;
  localparam int DIN_ERR  = 73;
  localparam int DIN_W    = 74;

  typedef struct packed {
    logic        err;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } din_t;

  typedef enum logic [2:0] {HDR0, HDR1, PAYLOAD, PAD, SKIP} decap_state_t;

  // Byte enables for the next payload word given the bytes still owed.
  function automatic logic [7:0] keep_for(input logic [15:0] rem);
    logic [8:0] w_mask;
    w_mask = (9'd1 << rem[2:0]) - 9'd1;
    if (rem >= 16'd8) return 8'hFF;
    return w_mask[7:0];
  endfunction

  // The MAC delivers byte 0 in [7:0]; MAC addresses are written MSB-first.
  function automatic logic [47:0] wire_to_mac(input logic [47:0] d);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[8*i +: 8] = d[40-8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/eth_decap_if.sv
// MAC RX stream in, eth2pcie FIFO write port out.
// Handshake: the RX stream has no tready, so a beat is consumed on every
// cycle with tvalid=1; the FIFO side writes din when wr_en=1, and wr_en is
// never raised while full=1.
interface eth_decap_if
  import eth_pkg::*;
  ();
  logic             s_axis_rx_tvalid;
  logic [63:0]      s_axis_rx_tdata;
  logic [7:0]       s_axis_rx_tkeep;
  logic             s_axis_rx_tlast;
  logic             s_axis_rx_tuser;
  logic             wr_en;
  logic [DIN_W-1:0] din;
  logic             full;

  modport slave (
    input  s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
           s_axis_rx_tlast, s_axis_rx_tuser, full,
    output wr_en, din
  );

  modport master (
    output s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
           s_axis_rx_tlast, s_axis_rx_tuser, full,
    input  wr_en, din
  );
endinterface

// File: rtl/eth_decap_stats.sv
// Three saturating frame counters driven by single-cycle strobes.
module eth_decap_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc_ok,
  input  logic        i_inc_drop,
  input  logic        i_inc_ovf,
  output logic [31:0] o_ok,
  output logic [31:0] o_drop,
  output logic [31:0] o_ovf
);
  logic [31:0] r_ok, r_drop, r_ovf;

  // Count each strobe, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ok   <= '0;
      r_drop <= '0;
      r_ovf  <= '0;
    end else begin
      if (i_inc_ok   && r_ok   != 32'hFFFF_FFFF) r_ok   <= r_ok   + 32'd1;
      if (i_inc_drop && r_drop != 32'hFFFF_FFFF) r_drop <= r_drop + 32'd1;
      if (i_inc_ovf  && r_ovf  != 32'hFFFF_FFFF) r_ovf  <= r_ovf  + 32'd1;
    end
  end

  assign o_ok   = r_ok;
  assign o_drop = r_drop;
  assign o_ovf  = r_ovf;
endmodule

// File: rtl/eth_decap.sv
// Ethernet RX decapsulation: filters tunnel frames, strips the 16-byte
// header, trims MAC padding and writes payload words to the eth2pcie FIFO.
// Output runs one word behind input so the last word can carry the error.
module eth_decap
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] ETH_TYPE  = 16'h88B5,
  parameter logic [15:0] MAX_LEN   = 16'd1024,
  parameter bit          FILTER_EN = 1'b1
) (
  input  logic          clk156,
  input  logic          sys_rst,
  eth_decap_if.slave    bus,
  output logic [31:0]   stat_frames_ok,
  output logic [31:0]   stat_frames_drop,
  output logic [31:0]   stat_overflow,
  output decap_state_t  o_dbg_state
);
  decap_state_t r_state, w_state_nxt;
  logic [47:0]  r_dst, w_dst_nxt;
  logic [15:0]  r_rem, w_rem_nxt;
  din_t         r_hold, w_hold_nxt;
  logic         r_hold_valid, w_hold_valid_nxt;
  logic         r_flush, w_flush_nxt;

  logic         w_wr_en;
  din_t         w_din;
  logic         w_inc_ok, w_inc_drop, w_inc_ovf;
  logic [15:0]  w_etype, w_len, w_rem_dec;
  logic [7:0]   w_keep;
  logic         w_mac_ok, w_reject;
  logic         w_unused;

  assign w_etype   = {bus.s_axis_rx_tdata[39:32], bus.s_axis_rx_tdata[47:40]};
  assign w_len     = {bus.s_axis_rx_tdata[55:48], bus.s_axis_rx_tdata[63:56]};
  assign w_mac_ok  = !FILTER_EN || (wire_to_mac(r_dst) == LOCAL_MAC) ||
                     (wire_to_mac(r_dst) == BCAST_MAC);
  assign w_reject  = !w_mac_ok || (w_etype != ETH_TYPE) || (w_len == 16'd0) ||
                     (w_len > MAX_LEN) || r_flush;
  assign w_keep    = keep_for(r_rem);
  assign w_rem_dec = r_rem - ((r_rem >= 16'd8) ? 16'd8 : r_rem);
  // tkeep is redundant: payload bytes are derived from the length field.
  assign w_unused  = ^bus.s_axis_rx_tkeep;

  // State, header and hold-word registers.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= HDR0;
      r_dst        <= '0;
      r_rem        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dst        <= w_dst_nxt;
      r_rem        <= w_rem_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_flush      <= w_flush_nxt;
    end
  end

  // Next-state, FIFO write and statistics strobes.
  always_comb begin
    w_state_nxt      = r_state;
    w_dst_nxt        = r_dst;
    w_rem_nxt        = r_rem;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;
    w_flush_nxt      = r_flush;
    w_wr_en          = 1'b0;
    w_din            = r_hold;
    w_inc_ok         = 1'b0;
    w_inc_drop       = 1'b0;
    w_inc_ovf        = 1'b0;

    // A pending final word goes out as soon as the FIFO has room; this
    // only overlaps HDR0/HDR1/SKIP, which never write themselves.
    if (r_flush && !bus.full) begin
      w_wr_en          = 1'b1;
      w_flush_nxt      = 1'b0;
      w_hold_valid_nxt = 1'b0;
      w_inc_ok         = !r_hold.err;
    end

    if (bus.s_axis_rx_tvalid) begin
      case (r_state)
        HDR0: begin
          w_dst_nxt = bus.s_axis_rx_tdata[47:0];
          if (bus.s_axis_rx_tlast) w_inc_drop  = 1'b1;
          else                     w_state_nxt = HDR1;
        end
        HDR1: begin
          if (bus.s_axis_rx_tlast) begin
            w_inc_drop  = 1'b1;
            w_state_nxt = HDR0;
          end else if (w_reject) begin
            w_inc_drop  = 1'b1;
            w_state_nxt = SKIP;
          end else begin
            w_rem_nxt   = w_len;
            w_state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (r_hold_valid && bus.full) begin
            // Cannot write the held word: close the frame with a terminator.
            w_hold_nxt       = '{err: 1'b1, last: 1'b1, keep: 8'h00, data: 64'h0};
            w_hold_valid_nxt = 1'b1;
            w_flush_nxt      = 1'b1;
            w_inc_ovf        = 1'b1;
            w_state_nxt      = bus.s_axis_rx_tlast ? HDR0 : SKIP;
          end else begin
            w_wr_en          = r_hold_valid;
            w_hold_nxt       = '{err: 1'b0, last: 1'b0, keep: w_keep,
                                 data: bus.s_axis_rx_tdata};
            w_hold_valid_nxt = 1'b1;
            w_rem_nxt        = w_rem_dec;
            if (bus.s_axis_rx_tlast) begin
              w_hold_nxt.last = 1'b1;
              w_hold_nxt.err  = !bus.s_axis_rx_tuser || (w_rem_dec != 16'd0);
              w_flush_nxt     = 1'b1;
              w_state_nxt     = HDR0;
            end else if (w_rem_dec == 16'd0) begin
              w_state_nxt = PAD;
            end
          end
        end
        PAD: begin
          if (bus.s_axis_rx_tlast) begin
            w_hold_nxt.last = 1'b1;
            w_hold_nxt.err  = !bus.s_axis_rx_tuser;
            w_flush_nxt     = 1'b1;
            w_state_nxt     = HDR0;
          end
        end
        SKIP: begin
          if (bus.s_axis_rx_tlast) w_state_nxt = HDR0;
        end
        default: w_state_nxt = HDR0;
      endcase
    end
  end

  assign bus.wr_en   = w_wr_en;
  assign bus.din     = w_din;
  assign o_dbg_state = r_state;

  eth_decap_stats u_stats (
    .clk        (clk156),
    .rst        (sys_rst),
    .i_inc_ok   (w_inc_ok),
    .i_inc_drop (w_inc_drop),
    .i_inc_ovf  (w_inc_ovf),
    .o_ok       (stat_frames_ok),
    .o_drop     (stat_frames_drop),
    .o_ovf      (stat_overflow)
  );
endmodule

// File: tb/tb_eth_decap.sv
// Bench for eth_decap: builds wire-order frames, predicts FIFO words into a
// scoreboard queue and compares every FIFO write plus the counters.
module tb_eth_decap;
  import eth_pkg::*;

  localparam logic [47:0] MAC_LOCAL = 48'h000A35000001;
  localparam logic [47:0] MAC_OTHER = 48'h020000000009;
  localparam logic [47:0] MAC_BC    = 48'hFFFFFFFFFFFF;

  // ---------------- clock / reset ----------------
  logic clk156 = 1'b0;
  logic sys_rst;
  always #5 clk156 = ~clk156;

  eth_decap_if bus ();
  logic [31:0]  stat_ok, stat_drop, stat_ovf;
  decap_state_t dbg_state;

  eth_decap dut (
    .clk156           (clk156),
    .sys_rst          (sys_rst),
    .bus              (bus),
    .stat_frames_ok   (stat_ok),
    .stat_frames_drop (stat_drop),
    .stat_overflow    (stat_ovf),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]       fr [0:2047];
  logic [DIN_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fails  = 0;
  int exp_ok   = 0;
  int exp_drop = 0;
  int exp_ovf  = 0;

  task automatic check(input string tag, input logic [DIN_W-1:0] got,
                       input logic [DIN_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.s_axis_rx_tvalid = 1'b0;
    bus.s_axis_rx_tlast  = 1'b0;
    bus.s_axis_rx_tuser  = 1'b0;
    bus.full             = 1'b0;
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype,
                             input logic [15:0] len, input int nbytes);
    for (int i = 0; i < 6; i++) fr[i] = dst[47-8*i -: 8];
    for (int i = 6; i < 12; i++) fr[i] = 8'(8'h10 + i);
    fr[12] = etype[15:8];
    fr[13] = etype[7:0];
    fr[14] = len[15:8];
    fr[15] = len[7:0];
    for (int i = 16; i < nbytes + 8; i++) fr[i] = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [63:0] beat_data(input int b);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = fr[8*b + j];
    return d;
  endfunction

  // Drives the frame in fr[]; full is raised on beats [full_from, full_from+full_len).
  task automatic send_frame(input int nbytes, input logic tuser,
                            input int full_from, input int full_len);
    int nb;
    int r;
    nb = (nbytes + 7) / 8;
    r  = nbytes % 8;
    for (int b = 0; b < nb; b++) begin
      bus.s_axis_rx_tvalid = 1'b1;
      bus.s_axis_rx_tdata  = beat_data(b);
      bus.s_axis_rx_tkeep  = (b == nb - 1 && r != 0) ? 8'((9'd1 << r) - 9'd1) : 8'hFF;
      bus.s_axis_rx_tlast  = (b == nb - 1);
      bus.s_axis_rx_tuser  = (b == nb - 1) ? tuser : 1'b0;
      bus.full             = (b >= full_from && b < full_from + full_len);
      @(posedge clk156);
      #1;
    end
    bus.s_axis_rx_tvalid = 1'b0;
    bus.s_axis_rx_tlast  = 1'b0;
    bus.s_axis_rx_tuser  = 1'b0;
    bus.full             = 1'b0;
  endtask

  // Reference model: decide acceptance and queue the FIFO words of fr[].
  task automatic model_frame(input int nbytes, input logic tuser);
    logic [47:0] dst;
    logic [15:0] etype, len;
    int nb, npw, avail, nw, left;
    logic [7:0]  keep;
    logic        last, err;
    for (int i = 0; i < 6; i++) dst[47-8*i -: 8] = fr[i];
    etype = {fr[12], fr[13]};
    len   = {fr[14], fr[15]};
    nb    = (nbytes + 7) / 8;
    if (nb < 3 || !(dst == MAC_LOCAL || dst == MAC_BC) || etype != 16'h88B5 ||
        len == 16'd0 || len > 16'd1024) begin
      exp_drop++;
      return;
    end
    npw   = (int'(len) + 7) / 8;
    avail = nb - 2;
    nw    = (avail < npw) ? avail : npw;
    for (int k = 0; k < nw; k++) begin
      left = int'(len) - 8 * k;
      keep = (left >= 8) ? 8'hFF : 8'((9'd1 << left) - 9'd1);
      last = (k == nw - 1);
      err  = last && (!tuser || avail < npw);
      exp_q.push_back({err, last, keep, beat_data(2 + k)});
    end
    if (!(!tuser || avail < npw)) exp_ok++;
  endtask

  task automatic run_frame(input logic [47:0] dst, input logic [15:0] etype,
                           input logic [15:0] len, input int nbytes,
                           input logic tuser, input int gap);
    build_frame(dst, etype, len, nbytes);
    model_frame(nbytes, tuser);
    send_frame(nbytes, tuser, -1, 0);
    if (gap > 0) idle(gap);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_ok"},   74'(stat_ok),   74'(exp_ok));
    check({tag, "_drop"}, 74'(stat_drop), 74'(exp_drop));
    check({tag, "_ovf"},  74'(stat_ovf),  74'(exp_ovf));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk156) begin
    if (!sys_rst) begin
      if (bus.full) check("wr_while_full", 74'(bus.wr_en), 74'(0));
      if (bus.wr_en) begin
        if (exp_q.size() == 0) check("spurious_wr", 74'(bus.wr_en), 74'(0));
        else check("din", bus.din, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len, nbytes;
    logic tuser;
    sys_rst              = 1'b1;
    bus.s_axis_rx_tvalid = 1'b0;
    bus.s_axis_rx_tdata  = '0;
    bus.s_axis_rx_tkeep  = '0;
    bus.s_axis_rx_tlast  = 1'b0;
    bus.s_axis_rx_tuser  = 1'b0;
    bus.full             = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    check("rst_wr_en", 74'(bus.wr_en), 74'(0));
    check("rst_din",   bus.din, 74'(0));
    check("rst_state", 74'(dbg_state), 74'(HDR0));
    check_stats("rst");
    sys_rst = 1'b0;
    idle(2);

    // Good L=20 frame, 64 bytes.
    run_frame(MAC_LOCAL, 16'h88B5, 16'd20, 64, 1'b1, 3);
    check_stats("good20");
    // L=12 in a minimum 60-byte padded frame.
    run_frame(MAC_LOCAL, 16'h88B5, 16'd12, 60, 1'b1, 3);
    // Filtered destination, then the same frame to broadcast.
    run_frame(MAC_OTHER, 16'h88B5, 16'd20, 64, 1'b1, 3);
    check_stats("filter");
    run_frame(MAC_BC, 16'h88B5, 16'd20, 64, 1'b1, 3);
    // Bad FCS on tlast.
    run_frame(MAC_LOCAL, 16'h88B5, 16'd20, 64, 1'b0, 3);
    check_stats("badfcs");

    // Overflow: L=64, full on beats 4..6 (while payload word 1 is due).
    build_frame(MAC_LOCAL, 16'h88B5, 16'd64, 80);
    exp_q.push_back({1'b0, 1'b0, 8'hFF, beat_data(2)});
    exp_q.push_back({1'b1, 1'b1, 8'h00, 64'h0});
    exp_ovf++;
    send_frame(80, 1'b1, 4, 3);
    idle(3);
    check_stats("ovf");
    run_frame(MAC_LOCAL, 16'h88B5, 16'd24, 64, 1'b1, 3);

    // Back-to-back frames with no idle between them.
    run_frame(MAC_LOCAL, 16'h88B5, 16'd16, 60, 1'b1, 0);
    run_frame(MAC_LOCAL, 16'h88B5, 16'd33, 60, 1'b1, 0);
    run_frame(MAC_BC,    16'h88B5, 16'd8,  60, 1'b1, 3);

    // Runts and header rejects.
    run_frame(MAC_LOCAL, 16'h88B5, 16'd20, 16,   1'b1, 2);
    run_frame(MAC_LOCAL, 16'h88B5, 16'd20, 8,    1'b1, 2);
    run_frame(MAC_LOCAL, 16'h0800, 16'd20, 64,   1'b1, 2);
    run_frame(MAC_LOCAL, 16'h88B5, 16'd0,  64,   1'b1, 2);
    run_frame(MAC_LOCAL, 16'h88B5, 16'd1025, 1041, 1'b1, 2);
    check_stats("reject");
    // Length limits and truncation.
    run_frame(MAC_LOCAL, 16'h88B5, 16'd1024, 1040, 1'b1, 2);
    run_frame(MAC_LOCAL, 16'h88B5, 16'd40, 32, 1'b1, 2);
    run_frame(MAC_LOCAL, 16'h88B5, 16'd1, 60, 1'b1, 2);

    // Random frames.
    for (int i = 0; i < 8; i++) begin
      len    = $urandom_range(1, 120);
      nbytes = (16 + len < 60) ? 60 : 16 + len;
      tuser  = ($urandom_range(0, 7) != 0);
      run_frame(MAC_LOCAL, 16'h88B5, 16'(len), nbytes, tuser, $urandom_range(0, 2));
    end
    idle(3);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk156);
    #1;
    check("drain", 74'(exp_q.size()), 74'(0));
    check_stats("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard time limit in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
